// File: rtl/quad_pkg.sv
// Shared types and phase-decode helpers for the quadrature decoder.
package quad_pkg;

  typedef enum logic [1:0] {
    QUAD_X1 = 2'd0,
    QUAD_X2 = 2'd1,
    QUAD_X4 = 2'd2
  } quad_mode_e;

  typedef logic [1:0] quad_phase_t;  // {A, B}

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } quad_step_e;

  // Successor of a phase in the up direction: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic quad_phase_t quad_next_up(input quad_phase_t p);
    quad_phase_t n;
    case (p)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // Classify the move from the previous phase to the current one.
  function automatic quad_step_e quad_decode(input quad_phase_t p, input quad_phase_t s);
    quad_step_e r;
    if (s == p)                    r = NONE;
    else if ((s ^ p) == 2'b11)     r = ILLEGAL;
    else if (s == quad_next_up(p)) r = UP;
    else                           r = DOWN;
    return r;
  endfunction

  // Resolution gate: does this legal transition count in the given mode.
  function automatic logic quad_counts(input quad_mode_e m, input quad_phase_t p,
                                       input quad_phase_t s);
    logic r;
    case (m)
      QUAD_X1: r = ((p == 2'b01) && (s == 2'b00)) || ((p == 2'b00) && (s == 2'b01));
      QUAD_X2: r = (p[1] != s[1]);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser chain plus stability filter for one asynchronous encoder line.
// The filtered output is always registered, so a change reaches filt_o
// FILT_LEN + 1 cycles after it first appears at the synchroniser output.
module quad_input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw_i,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_c;
  logic                   filt_q;
  logic                   filt_d;

  // Metastability chain
  always_ff @(posedge clk) begin
    if (!nrst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  assign synced_c = sync_q[SYNC_STAGES-1];

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign filt_d = synced_c;
    end else begin : g_filter
      localparam int unsigned CW = $clog2(FILT_LEN + 1);
      logic [CW-1:0] run_q;
      logic [CW-1:0] run_d;

      // Run-length of disagreement; any reversion restarts the run
      always_comb begin
        run_d  = run_q;
        filt_d = filt_q;
        if (synced_c == filt_q) begin
          run_d = '0;
        end else if (run_q == CW'(FILT_LEN)) begin
          filt_d = synced_c;
          run_d  = '0;
        end else begin
          run_d = run_q + CW'(1);
        end
      end

      // Run counter register
      always_ff @(posedge clk) begin
        if (!nrst) run_q <= '0;
        else       run_q <= run_d;
      end
    end
  endgenerate

  // Filtered output register
  always_ff @(posedge clk) begin
    if (!nrst) filt_q <= 1'b0;
    else       filt_q <= filt_d;
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: deglitched A/B phase decode in X1/X2/X4
// resolution with a wrapping position counter, direction, step pulse and
// sticky illegal-transition flag.
// Optional index support is enabled by defining QUAD_INDEX_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             quad_z,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             err_clr,
  input  logic             idx_zero,
  input  logic             idx_ack,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [CNT_W-1:0] index_pos,
  output logic             index_valid
);

  logic             a_f;
  logic             b_f;
  quad_phase_t      phase_c;
  quad_phase_t      prev_q, prev_d;
  logic             primed_q;
  logic [1:0]       mode_q;
  quad_mode_e       mode_e;
  quad_step_e       dec_c;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             idx_zero_c;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .nrst(nrst), .raw_i(quad_a), .filt_o(a_f)
  );

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .nrst(nrst), .raw_i(quad_b), .filt_o(b_f)
  );

  assign phase_c = {a_f, b_f};
  assign dec_c   = quad_decode(prev_q, phase_c);
  assign mode_e  = (mode_q == 2'd3) ? QUAD_X4 : quad_mode_e'(mode_q);

`ifdef QUAD_INDEX_EN
  logic             z_f;
  logic             z_prev_q;
  logic             z_rise_c;
  logic [CNT_W-1:0] index_pos_q;
  logic             index_valid_q;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
    .clk(clk), .nrst(nrst), .raw_i(quad_z), .filt_o(z_f)
  );

  assign z_rise_c   = z_f & ~z_prev_q;
  assign idx_zero_c = z_rise_c & idx_zero;

  // Index capture of the pre-update count; a capture beats a same-cycle ack
  always_ff @(posedge clk) begin
    if (!nrst) begin
      z_prev_q      <= 1'b0;
      index_pos_q   <= '0;
      index_valid_q <= 1'b0;
    end else begin
      z_prev_q <= z_f;
      if (z_rise_c) begin
        index_pos_q   <= count_q;
        index_valid_q <= 1'b1;
      end else if (idx_ack) begin
        index_valid_q <= 1'b0;
      end
    end
  end

  assign index_pos   = index_pos_q;
  assign index_valid = index_valid_q;
`else
  logic unused_index_inputs;
  assign unused_index_inputs = &{1'b0, quad_z, idx_zero, idx_ack};
  assign idx_zero_c  = 1'b0;
  assign index_pos   = '0;
  assign index_valid = 1'b0;
`endif

  // Next-state: priming, step decode, then index-zero and clear overrides
  always_comb begin
    prev_d  = phase_c;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q & ~err_clr;
    if (primed_q) begin
      if (dec_c == ILLEGAL) begin
        err_d = 1'b1;
      end else if ((dec_c != NONE) && quad_counts(mode_e, prev_q, phase_c)) begin
        count_d = (dec_c == UP) ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
        dir_d   = (dec_c == UP);
        step_d  = 1'b1;
      end
    end
    if (clear || idx_zero_c) begin
      count_d = '0;
      dir_d   = dir_q;
      step_d  = 1'b0;
    end
  end

  // State registers; the first cycle after reset only loads prev
  always_ff @(posedge clk) begin
    if (!nrst) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      mode_q   <= 2'd0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= 1'b1;
      mode_q   <= mode;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule
